reg_pipeline: RTL and testbench

Parametrised elastic register pipeline, generalising the team's single enabled register into a DEPTH-stage, WIDTH-bit chain with a valid/ready handshake on both ends. Empty stages (bubbles) collapse, a synchronous flush discards in-flight data, and a registered occupancy count is exposed. It sits between producer and consumer blocks that need a fixed register delay while still honouring back-pressure.

---
 rtl/reg_pipeline.sv | 91 +++++++++
 tb/tb_reg_pipeline.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/reg_pipeline.sv
// reg_pipeline: DEPTH-stage, WIDTH-bit elastic register chain.
//   Valid/ready handshake on both ends. Bubbles collapse toward the output,
//   and a synchronous flush drops every in-flight word. A registered
//   occupancy count is exposed.
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   flush     synchronous clear of all in-flight entries
//   in_valid  producer offers in_data
//   in_ready  pipeline accepts in_data this cycle (combinational from out_ready)
//   in_data   input word
//   out_valid last stage holds a valid word (registered)
//   out_ready consumer accepts out_data this cycle
//   out_data  word held in the last stage (registered)
//   count     number of valid stages, 0..DEPTH (registered)
module reg_pipeline #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int unsigned     CW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [CW-1:0]    count_q;
    logic [DEPTH-1:0] rdy_c;
    logic             in_xfer_c;
    logic             out_xfer_c;

    // Ready ripples from the output back; a running bit avoids a self-looped vector.
    always_comb begin
        logic r;
        rdy_c          = '0;
        r              = !valid_q[DEPTH-1] || out_ready;
        rdy_c[DEPTH-1] = r;
        for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
            r        = !valid_q[i] || r;
            rdy_c[i] = r;
        end
    end

    assign in_ready   = rdy_c[0] && !flush;
    assign in_xfer_c  = in_valid && in_ready;
    assign out_xfer_c = valid_q[DEPTH-1] && out_ready;

    // Stage registers. Data loads only when a valid word arrives, so bubbles leave data untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= RESET_VAL;
            end
        end else if (flush) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            if (rdy_c[0]) begin
                valid_q[0] <= in_valid;
                if (in_valid) begin
                    data_q[0] <= in_data;
                end
            end
            for (int i = 1; i < int'(DEPTH); i++) begin
                if (rdy_c[i]) begin
                    valid_q[i] <= valid_q[i-1];
                    if (valid_q[i-1]) begin
                        data_q[i] <= data_q[i-1];
                    end
                end
            end
            count_q <= count_q + CW'(in_xfer_c) - CW'(out_xfer_c);
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign count     = count_q;

endmodule

// File: tb/tb_reg_pipeline.sv
// tb_reg_pipeline: scoreboard bench for reg_pipeline (WIDTH=8, DEPTH=4, RESET_VAL=8'hA5).
//   Accepted words are queued when driven and compared in order as they emerge.
module tb_reg_pipeline;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam logic [WIDTH-1:0] RST_V = 8'hA5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] sb [$];
    int               mcnt;
    int               n_checks = 0;
    int               n_fail   = 0;

    reg_pipeline #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .RESET_VAL(RST_V)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check handshake, update scoreboard, check count after the edge.
    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic ordy, input logic fl);
        logic exp_rdy;
        logic [WIDTH-1:0] w;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        exp_rdy = !fl && (mcnt < int'(DEPTH) || ordy);
        check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (sb.size() == 0) check_eq("spurious_out_valid", 32'(out_valid), 32'd0);
        if (out_valid && ordy && sb.size() != 0) begin
            w = sb.pop_front();
            check_eq("out_data", 32'(out_data), 32'(w));
            mcnt--;
        end
        if (fl) begin
            sb.delete();
            mcnt = 0;
        end else if (v && exp_rdy) begin
            sb.push_back(d);
            mcnt++;
        end
        @(posedge clk);
        #1;
        check_eq("count", 32'(count), 32'(mcnt));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        mcnt = 0;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'(RST_V));
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    // Drain remaining words with out_ready high; a bounded loop flags a stuck pipeline.
    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 50) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            guard++;
        end
        check_eq("drain_done", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        mcnt = 0;
        do_reset();

        // Streaming: first word valid after DEPTH edges, then one per cycle.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i + 1), 1'b1, 1'b0);
            if (i < 4) check_eq("stream_latency", 32'(out_valid), 32'(i >= 3));
            if (i >= 4) check_eq("stream_steady_count", 32'(count), 32'd4);
        end
        drain();

        // Back-pressure fill: only four of six accepted.
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h21 + i), 1'b0, 1'b0);
        check_eq("full_in_ready", 32'(in_ready), 32'd0);
        check_eq("full_out_data", 32'(out_data), 32'h21);
        drain();

        // Bubble collapse: single word reaches the output after 4 edges.
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        check_eq("bubble_ov0", 32'(out_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            check_eq("bubble_ov", 32'(out_valid), 32'(i == 2));
        end
        check_eq("bubble_count1", 32'(count), 32'd1);
        step(1'b1, 8'h3D, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("bubble_count2", 32'(count), 32'd2);
        check_eq("bubble_head", 32'(out_data), 32'h3C);
        drain();

        // Flush with count=3 and a pending word: nothing survives, 8'hFF never emitted.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
        check_eq("pre_flush_count", 32'(count), 32'd3);
        step(1'b1, 8'hFF, 1'b0, 1'b1);
        check_eq("flush_out_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Reset mid-stream, then normal latency again.
        step(1'b1, 8'h71, 1'b1, 1'b0);
        step(1'b1, 8'h72, 1'b1, 1'b0);
        check_eq("pre_reset_count", 32'(count), 32'd2);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
            if (i < 4) check_eq("post_reset_latency", 32'(out_valid), 32'(i >= 3));
        end
        drain();

        // Random traffic through the scoreboard.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 40) == 0));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
